mem_wr_arbiter: RTL and testbench

MEM_WR_ARBITER -- requirements
Module: mem_wr_arbiter

---
 rtl/mem_wr_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_wr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wr_arbiter.sv
// Purpose: round-robin write arbiter (fill fifo vs wbuffer) onto one AXI AW/W port, with an
//          outstanding-write table that blocks reads to lines still in flight.
// Latency: grant registered, AW/W valid one cycle after eligibility; AR path is combinational.
module mem_wr_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int ID_W     = 16,
  parameter int MAX_OUTS = 4
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0: fill fifo
  input  logic [ID_W-1:0]   f_awid_i,
  input  logic [ADDR_W-1:0] f_awaddr_i,
  input  logic              f_awvalid_i,
  output logic              f_awready_o,
  input  logic [DATA_W-1:0] f_wdata_i,
  input  logic              f_wvalid_i,
  output logic              f_wready_o,
  // requester 1: write buffer
  input  logic [ID_W-1:0]   b_awid_i,
  input  logic [ADDR_W-1:0] b_awaddr_i,
  input  logic              b_awvalid_i,
  output logic              b_awready_o,
  input  logic [DATA_W-1:0] b_wdata_i,
  input  logic              b_wvalid_i,
  output logic              b_wready_o,
  // lookup read path
  input  logic [ID_W-1:0]   l_arid_i,
  input  logic [ADDR_W-1:0] l_araddr_i,
  input  logic              l_arvalid_i,
  output logic              l_arready_o,
  // memory controller
  output logic [ID_W-1:0]   m_awid_o,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [ID_W-1:0]   m_wid_o,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  output logic [ID_W-1:0]   m_arid_o,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  input  logic [ID_W-1:0]   m_bid_i,
  input  logic              m_bvalid_i,
  output logic              m_bready_o,
  // status
  output logic              err_o
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam int LW = ADDR_W - 6;
  localparam int PW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
  localparam int CW = $clog2(MAX_OUTS + 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_OUTS);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTS - 1);

  state_t              state, state_nxt;
  logic                grant, sel, xfer_end;
  logic                gnt_q, ptr_q, aw_done_q, w_done_q, err_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [LW-1:0]       tbl [MAX_OUTS];
  logic [MAX_OUTS-1:0] tbl_vld;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                f_elig, b_elig, aw_hs, w_hs, b_hs, push, pop, hazard;
  logic                unused_bid;

  // B responses are matched in order, so the returned id carries no extra information
  assign unused_bid = ^m_bid_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign f_elig   = f_awvalid_i & f_wvalid_i;
  assign b_elig   = b_awvalid_i & b_wvalid_i;
  assign aw_hs    = m_awvalid_o & m_awready_i;
  assign w_hs     = m_wvalid_o & m_wready_i;
  assign b_hs     = m_bvalid_i & m_bready_o;
  assign push     = aw_hs;
  assign pop      = b_hs & (count != '0);
  assign xfer_end = (aw_done_q | aw_hs) & (w_done_q | w_hs);

  // next-state and grant selection: pointer's requester wins if eligible, else the other one
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    sel       = ptr_q ? b_elig : ~f_elig;
    case (state)
      IDLE: if ((f_elig | b_elig) && (count < FULL)) begin
        grant     = 1'b1;
        state_nxt = XFER;
      end
      XFER: if (xfer_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // grant capture, round-robin pointer and per-channel done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= 1'b0;
      ptr_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else if (grant) begin
      gnt_q     <= sel;
      ptr_q     <= ~sel;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      id_q      <= sel ? b_awid_i   : f_awid_i;
      addr_q    <= sel ? b_awaddr_i : f_awaddr_i;
      data_q    <= sel ? b_wdata_i  : f_wdata_i;
    end else if (state == XFER) begin
      if (xfer_end) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
    end
  end

  // outstanding-line FIFO: push on AW accept, pop on B; B with nothing outstanding is an error
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTS; i++) tbl[i] <= '0;
      tbl_vld <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        tbl[wr_ptr]     <= addr_q[ADDR_W-1:6];
        tbl_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        tbl_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end
      if (b_hs && (count == '0)) err_q <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // read hazard: line still in the table, or the line currently being written
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < MAX_OUTS; i++)
      if (tbl_vld[i] && (tbl[i] == l_araddr_i[ADDR_W-1:6])) hazard = 1'b1;
    if ((state == XFER) && (addr_q[ADDR_W-1:6] == l_araddr_i[ADDR_W-1:6])) hazard = 1'b1;
  end

  assign m_awid_o    = id_q;
  assign m_awaddr_o  = addr_q;
  assign m_awvalid_o = (state == XFER) & ~aw_done_q;
  assign m_wid_o     = id_q;
  assign m_wdata_o   = data_q;
  assign m_wvalid_o  = (state == XFER) & ~w_done_q;
  assign f_awready_o = m_awvalid_o & ~gnt_q & m_awready_i;
  assign f_wready_o  = m_wvalid_o  & ~gnt_q & m_wready_i;
  assign b_awready_o = m_awvalid_o &  gnt_q & m_awready_i;
  assign b_wready_o  = m_wvalid_o  &  gnt_q & m_wready_i;
  assign m_arid_o    = l_arid_i;
  assign m_araddr_o  = l_araddr_i;
  assign m_arvalid_o = l_arvalid_i & ~hazard;
  assign l_arready_o = m_arready_i & ~hazard;
  assign m_bready_o  = ~rst;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Purpose: self-checking bench for mem_wr_arbiter: vector table, directed corner sequences, random run.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: memory-side readies and B responses are driven by the bench (fixed or random).
module tb_mem_wr_arbiter;
  localparam int AW = 64, DW = 512, IW = 16, MO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [IW-1:0] f_awid_i, b_awid_i, l_arid_i, m_awid_o, m_wid_o, m_arid_o, m_bid_i;
  logic [AW-1:0] f_awaddr_i, b_awaddr_i, l_araddr_i, m_awaddr_o, m_araddr_o;
  logic [DW-1:0] f_wdata_i, b_wdata_i, m_wdata_o;
  logic f_awvalid_i, f_awready_o, f_wvalid_i, f_wready_o;
  logic b_awvalid_i, b_awready_o, b_wvalid_i, b_wready_o;
  logic l_arvalid_i, l_arready_o, m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
  logic m_arvalid_o, m_arready_i, m_bvalid_i, m_bready_o, err_o;

  always #5 clk = ~clk;

  mem_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTS(MO)) dut (
    .clk(clk), .rst(rst),
    .f_awid_i(f_awid_i), .f_awaddr_i(f_awaddr_i), .f_awvalid_i(f_awvalid_i), .f_awready_o(f_awready_o),
    .f_wdata_i(f_wdata_i), .f_wvalid_i(f_wvalid_i), .f_wready_o(f_wready_o),
    .b_awid_i(b_awid_i), .b_awaddr_i(b_awaddr_i), .b_awvalid_i(b_awvalid_i), .b_awready_o(b_awready_o),
    .b_wdata_i(b_wdata_i), .b_wvalid_i(b_wvalid_i), .b_wready_o(b_wready_o),
    .l_arid_i(l_arid_i), .l_araddr_i(l_araddr_i), .l_arvalid_i(l_arvalid_i), .l_arready_o(l_arready_o),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wid_o(m_wid_o), .m_wdata_o(m_wdata_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_bid_i(m_bid_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .err_o(err_o));

  typedef struct { logic [IW-1:0] id; logic [AW-1:0] addr; logic [DW-1:0] data; } txn_t;

  int checks = 0, errors = 0;

  // requester-side drivers
  txn_t fq[$], bq[$];
  logic f_go, b_go, f_awtk, f_wtk, b_awtk, b_wtk, perm, ar_rdy;

  // transaction-level reference model
  logic busy, msel, aw_seen, w_seen, rr, err_m, last_awv;
  txn_t cur;
  logic [AW-7:0] outq[$];
  int aw_log[$];
  int aw_cnt, w_cnt;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    fq.delete(); bq.delete(); outq.delete(); aw_log.delete();
    f_go = 0; b_go = 0; f_awtk = 0; f_wtk = 0; b_awtk = 0; b_wtk = 0;
    busy = 0; msel = 0; aw_seen = 0; w_seen = 0; rr = 0; err_m = 0; last_awv = 0;
    aw_cnt = 0; w_cnt = 0; perm = 1; ar_rdy = 1;
    cur = '{id: '0, addr: '0, data: '0};
  endtask

  task automatic idle_inputs();
    f_awvalid_i = 0; f_wvalid_i = 0; b_awvalid_i = 0; b_wvalid_i = 0;
    f_awid_i = 0; f_awaddr_i = 0; f_wdata_i = 0; b_awid_i = 0; b_awaddr_i = 0; b_wdata_i = 0;
    l_arid_i = 0; l_araddr_i = 0; l_arvalid_i = 0; m_arready_i = 1;
    m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bid_i = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; idle_inputs();
    @(posedge clk); @(negedge clk);
    chk("rst_bready", m_bready_o, 0);
    @(posedge clk); @(negedge clk);
    chk("rst_valids", {m_awvalid_o, m_wvalid_o}, 0);
    chk("rst_count", dut.count, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk); #1;
    rst = 0;
    clear_model();
  endtask

  function automatic txn_t mk_txn(input int id, input int line);
    txn_t t;
    t.id   = IW'(id);
    t.addr = 64'h0000000f00000000 + (64'(line) << 6) + 64'($urandom_range(0, 63));
    t.data = {16{$urandom()}};
    return t;
  endfunction

  // one clock cycle: drive, sample, compare against the model, then advance model and drivers
  task automatic cyc(input logic awr, input logic wr, input logic bv, input logic arv, input logic [AW-1:0] ara);
    logic f_el, b_el, ahs, whs, haz, e_awv, e_wv, s;
    int pre;
    @(posedge clk); #1;
    if (perm) begin
      if (fq.size() > 0) f_go = 1;
      if (bq.size() > 0) b_go = 1;
    end
    f_awvalid_i = f_go & ~f_awtk; f_wvalid_i = f_go & ~f_wtk;
    b_awvalid_i = b_go & ~b_awtk; b_wvalid_i = b_go & ~b_wtk;
    if (fq.size() > 0) begin f_awid_i = fq[0].id; f_awaddr_i = fq[0].addr; f_wdata_i = fq[0].data; end
    if (bq.size() > 0) begin b_awid_i = bq[0].id; b_awaddr_i = bq[0].addr; b_wdata_i = bq[0].data; end
    m_awready_i = awr; m_wready_i = wr; m_bvalid_i = bv;
    l_arvalid_i = arv; l_araddr_i = ara; l_arid_i = IW'($urandom()); m_arready_i = ar_rdy;
    @(negedge clk);
    e_awv = busy & ~aw_seen;
    e_wv  = busy & ~w_seen;
    haz = 0;
    foreach (outq[i]) if (outq[i] == ara[AW-1:6]) haz = 1;
    if (busy && (cur.addr[AW-1:6] == ara[AW-1:6])) haz = 1;
    chk("awvalid", m_awvalid_o, e_awv);
    chk("wvalid", m_wvalid_o, e_wv);
    if (e_awv) begin chk("awaddr", m_awaddr_o, cur.addr); chk("awid", m_awid_o, cur.id); end
    if (e_wv)  begin chk("wdata", m_wdata_o, cur.data); chk("wid", m_wid_o, cur.id); end
    chk("readies", {f_awready_o, f_wready_o, b_awready_o, b_wready_o},
        {e_awv & ~msel & awr, e_wv & ~msel & wr, e_awv & msel & awr, e_wv & msel & wr});
    chk("arvalid", m_arvalid_o, arv & ~haz);
    chk("arready", l_arready_o, ar_rdy & ~haz);
    chk("ar_pass", {m_araddr_o, m_arid_o}, {ara, l_arid_i});
    chk("err", err_o, err_m);
    chk("count", dut.count, outq.size());
    chk("bready", m_bready_o, 1);
    last_awv = m_awvalid_o;
    if (m_awvalid_o & awr) begin aw_log.push_back(int'(m_awid_o)); aw_cnt++; end
    if (m_wvalid_o & wr) w_cnt++;
    // model advance for this edge
    f_el = f_awvalid_i & f_wvalid_i;
    b_el = b_awvalid_i & b_wvalid_i;
    ahs = e_awv & awr;
    whs = e_wv & wr;
    pre = outq.size();
    if (ahs) outq.push_back(cur.addr[AW-1:6]);
    if (bv) begin
      if (pre > 0) void'(outq.pop_front());
      else err_m = 1;
    end
    if (busy) begin
      aw_seen |= ahs; w_seen |= whs;
      if (aw_seen && w_seen) busy = 0;
    end else if ((f_el | b_el) && pre < MO) begin
      s = rr ? b_el : ~f_el;
      cur = s ? bq[0] : fq[0];
      busy = 1; msel = s; aw_seen = 0; w_seen = 0; rr = ~s;
    end
    // requester drivers retire a transaction once both its beats are accepted
    if (f_awvalid_i & f_awready_o) f_awtk = 1;
    if (f_wvalid_i & f_wready_o) f_wtk = 1;
    if (b_awvalid_i & b_awready_o) b_awtk = 1;
    if (b_wvalid_i & b_wready_o) b_wtk = 1;
    if (f_go && f_awtk && f_wtk) begin void'(fq.pop_front()); f_go = 0; f_awtk = 0; f_wtk = 0; end
    if (b_go && b_awtk && b_wtk) begin void'(bq.pop_front()); b_go = 0; b_awtk = 0; b_wtk = 0; end
  endtask

  typedef struct {
    logic fv, bv; logic [AW-1:0] ara;
    logic e_awv, e_fawr; int e_cnt; logic e_arv;
  } vec_t;
  vec_t vt[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    rst = 1; idle_inputs(); clear_model();

    // single fill write with read hazards around it
    vt[0] = '{1, 0, 64'h0000000f00000048, 0, 0, 0, 1};
    vt[1] = '{1, 0, 64'h0000000f00000048, 1, 1, 0, 0};
    vt[2] = '{0, 0, 64'h0000000f00000048, 0, 0, 1, 0};
    vt[3] = '{0, 0, 64'h0000000f00000080, 0, 0, 1, 1};
    vt[4] = '{0, 1, 64'h0000000f00000048, 0, 0, 1, 0};
    vt[5] = '{0, 0, 64'h0000000f00000048, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      f_awvalid_i = vt[i].fv; f_wvalid_i = vt[i].fv;
      f_awid_i = 1; f_awaddr_i = 64'h0000000f00000040; f_wdata_i = {128{4'hd}};
      m_awready_i = 1; m_wready_i = 1; m_bvalid_i = vt[i].bv; m_bid_i = 1;
      l_arvalid_i = 1; l_araddr_i = vt[i].ara; m_arready_i = 1;
      @(negedge clk);
      chk($sformatf("vec%0d_awvalid", i), m_awvalid_o, vt[i].e_awv);
      chk($sformatf("vec%0d_fawready", i), f_awready_o, vt[i].e_fawr);
      chk($sformatf("vec%0d_count", i), dut.count, vt[i].e_cnt);
      chk($sformatf("vec%0d_arvalid", i), m_arvalid_o, vt[i].e_arv);
      if (vt[i].e_awv) begin
        chk("vec_awaddr", m_awaddr_o, 64'h0000000f00000040);
        chk("vec_wid", m_wid_o, 1);
      end
    end

    // simultaneous requests: fill wins after reset; a lone fill then leaves the pointer on wbuffer
    do_reset();
    fq.push_back(mk_txn(2, 1)); bq.push_back(mk_txn(3, 2));
    for (int i = 0; i < 20 && aw_cnt < 2; i++) cyc(1, 1, 0, 0, 0);
    fq.push_back(mk_txn(4, 3));
    for (int i = 0; i < 20 && aw_cnt < 3; i++) cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(1, 1, 1, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0);
    fq.push_back(mk_txn(5, 4)); bq.push_back(mk_txn(6, 5));
    for (int i = 0; i < 20 && aw_cnt < 5; i++) cyc(1, 1, 0, 0, 0);
    chk("rr_count", aw_log.size(), 5);
    if (aw_log.size() == 5) begin
      chk("rr_first", aw_log[0], 2); chk("rr_second", aw_log[1], 3);
      chk("rr_pair2_first", aw_log[3], 6); chk("rr_pair2_second", aw_log[4], 5);
    end

    // backpressure: table full after four writes, one B lets the fifth through
    do_reset();
    for (int i = 0; i < 5; i++) fq.push_back(mk_txn(10 + i, 8 + i));
    for (int i = 0; i < 40 && aw_cnt < 4; i++) cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    chk("bp_four", aw_cnt, 4);
    chk("bp_held_elig", f_awvalid_i & f_wvalid_i, 1);
    chk("bp_held_ready", f_awready_o, 0);
    chk("bp_held_awvalid", m_awvalid_o, 0);
    cyc(1, 1, 1, 0, 0);
    seen = 0;
    repeat (2) begin cyc(1, 1, 0, 0, 0); if (last_awv) seen = 1; end
    chk("bp_fifth_issued", seen, 1);

    // split handshake: W first, AW held off three cycles
    do_reset();
    fq.push_back(mk_txn(20, 1));
    repeat (4) cyc(0, 1, 0, 0, 0);
    fq.push_back(mk_txn(21, 2));
    cyc(1, 1, 0, 0, 0);
    perm = 0;
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("split_aw_beats", aw_cnt, 1);
    chk("split_w_beats", w_cnt, 1);

    // error on stray B, then reset in the middle of a transfer
    do_reset();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("err_set", err_o, 1);
    fq.push_back(mk_txn(30, 1));
    cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("xfer_active", m_awvalid_o & m_wvalid_o, 1);
    @(posedge clk); #1;
    rst = 1; idle_inputs();
    @(posedge clk); #1;
    chk("mid_rst_valids", {m_awvalid_o, m_wvalid_o, m_arvalid_o}, 0);
    chk("mid_rst_count", dut.count, 0);
    chk("mid_rst_err", err_o, 0);
    rst = 0;
    clear_model();
    repeat (4) cyc(1, 1, 0, 0, 0);
    chk("no_reissue", aw_cnt + w_cnt, 0);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [AW-1:0] ra;
      if (fq.size() < 3 && $urandom_range(0, 3) == 0) fq.push_back(mk_txn(c, $urandom_range(0, 7)));
      if (bq.size() < 3 && $urandom_range(0, 3) == 0) bq.push_back(mk_txn(c + 40000, $urandom_range(0, 7)));
      perm = ($urandom_range(0, 1) == 1);
      ar_rdy = ($urandom_range(0, 3) != 0);
      ra = 64'h0000000f00000000 + (64'($urandom_range(0, 7)) << 6) + 64'($urandom_range(0, 63));
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
          (outq.size() > 0) && ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, ra);
    end
    chk("rand_progress", aw_cnt > 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
